zero_count_pattern_gen: RTL and testbench
=========================================

Name: zero_count_pattern_gen

Overview:
Generator counterpart to the zero-counting detector. Given a requested zero count K (0..8), the block emits, in ascending numeric order, every 8-bit value containing exactly K zero bits, one value per valid/ready transfer. It feeds the zero-count detector and downstream consumers with exhaustive stimulus, and acts as the encoder side (count -> byte) of the count interface.

Parameters:
WIDTH, 8, data width in bits; the block is verified only at 8.
KW, 4, width of zero_cnt; must represent 0..WIDTH.
IDX_W, 7, width of idx; must hold C(WIDTH, WIDTH/2)-1, which is 69 for WIDTH=8.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request a new sequence; sampled only in IDLE
zero_cnt  input  KW  requested zero count K; sampled together with start
ready  input  1  consumer accepts data this cycle
data  output  WIDTH  current pattern
valid  output  1  data is valid
last  output  1  data is the final pattern of the sequence; qualified by valid
idx  output  IDX_W  index of the current pattern, 0-based
busy  output  1  a sequence is in progress (RUN state)
done  output  1  one-cycle pulse after the final transfer
err  output  1  one-cycle pulse when start is sampled with zero_cnt > WIDTH

Behaviour:
- One clock; reset is asynchronous and active-high. While rst=1: data=0, valid=0, last=0, idx=0, busy=0, done=0, err=0, state=IDLE.
- States: IDLE, RUN.
- IDLE + start=1 + zero_cnt<=WIDTH: latch K and set P=WIDTH-K. Next cycle: state=RUN, valid=1, busy=1, idx=0, data=(1<<P)-1. Latency from start to first valid is 1 cycle.
- IDLE + start=1 + zero_cnt>WIDTH: err=1 for one cycle. State stays IDLE and no output is produced.
- start is ignored in RUN, and zero_cnt is ignored outside the start sample.
- Transfer occurs at a rising edge with valid=1 and ready=1.
- While valid=1 and ready=0, data, idx and last hold stable.
- After a non-final transfer, the next cycle presents the next pattern with no bubble:
  - next pattern = the smallest value greater than the current one with the same popcount P;
  - idx increments by 1.
- Arithmetic: the next-pattern computation uses WIDTH+1-bit intermediates so the carry is not lost. The recommended form is Gosper's step: c=x&-x, r=x+c, next=(((r^x)>>2)>>log2(c))|r. Division is not permitted.
- last=1 exactly when data equals the final pattern ((1<<P)-1)<<K.
  - For K=0 and K=WIDTH, the first pattern is also the last one, so last=1 from idx 0.
- Final transfer: the next cycle has valid=0, last=0, busy=0, done=1, state=IDLE.
  - done drops after 1 cycle.
  - A start asserted during the done cycle is accepted normally.
- Total transfers per sequence: C(WIDTH,K). For WIDTH=8, K=4 gives 70.
- rst mid-sequence aborts immediately. No done pulse is produced, and the next start begins again from idx 0.
- data holds its last value while valid=0; consumers must not use it.

Optional Feature:
ZERO_CHECK_EN: when defined, the block adds an internal combinational zero counter on data and a sticky output port chk_err (1 bit, reset 0).
- chk_err sets when valid=1 and the zero count of data differs from the latched K.
- chk_err clears only on rst.
When ZERO_CHECK_EN is undefined, the chk_err port and the check logic are absent, and behaviour is otherwise identical.

Test Plan:
- rst 2 cycles; start, zero_cnt=6, ready=1 -> 28 transfers.
  - data sequence 0x03,0x05,0x06,0x09,...,0xA0,0xC0; idx 0..27.
  - last=1 only on 0xC0; done pulses 1 cycle later; busy=0.
- zero_cnt=8 -> single transfer of 0x00 with last=1. zero_cnt=0 -> single transfer of 0xFF with last=1. Each is followed by a done pulse.
- zero_cnt=7; ready pattern 0,0,0,1,1,0,1,... -> data held at 0x01 for 3 stalled cycles.
  - Sequence 0x01,0x02,0x04,...,0x80 with no skips or repeats; last on 0x80.
- start with zero_cnt=9 -> err=1 for 1 cycle; valid, busy and done stay 0. A following start with zero_cnt=4 works, first data 0x0F.
- zero_cnt=4; assert rst asynchronously after 10 transfers (between edges) -> all outputs 0 immediately, no done.
  - Restart with zero_cnt=4 -> first data 0x0F, idx 0; 70 transfers, last 0xF0.
- Pulse start with zero_cnt=2 while busy on a K=5 sequence -> ignored; the sequence completes with 56 transfers.
  - With ZERO_CHECK_EN defined: chk_err stays 0 across all scenarios.

Source files
------------

// File: rtl/zero_count_pattern_gen.sv
// Emits, in ascending order, every WIDTH-bit value with exactly K zero bits, one per valid/ready transfer.
// Optional self-check of emitted zero counts with sticky chk_err when ZERO_CHECK_EN is defined.
module zero_count_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int KW    = 4,
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KW-1:0]    zero_cnt,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             last,
    output logic [IDX_W-1:0] idx,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef ZERO_CHECK_EN
    ,
    output logic             chk_err
`endif
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [KW-1:0]    k_q, k_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] first_pat, next_pat, final_pat_new, final_pat_cur;

    // Lowest (WIDTH-k) bits set: smallest value with k zeros.
    function automatic logic [WIDTH-1:0] first_pattern(input logic [KW-1:0] k);
        logic [WIDTH-1:0] p;
        for (int i = 0; i < WIDTH; i++) p[i] = (i < (WIDTH - int'(k)));
        return p;
    endfunction

    // Highest (WIDTH-k) bits set: largest value with k zeros.
    function automatic logic [WIDTH-1:0] final_pattern(input logic [KW-1:0] k);
        logic [WIDTH-1:0] p;
        for (int i = 0; i < WIDTH; i++) p[i] = (i >= int'(k));
        return p;
    endfunction

    // Gosper's step on a WIDTH+1 bit intermediate so the ripple carry survives.
    function automatic logic [WIDTH-1:0] next_pattern(input logic [WIDTH-1:0] x);
        logic [WIDTH:0] xe, c, r, t;
        int             sh;
        xe = {1'b0, x};
        c  = xe & (~xe + 1'b1);
        r  = xe + c;
        sh = 0;
        for (int i = 0; i <= WIDTH; i++) if (c[i]) sh = i;
        t  = ((r ^ xe) >> 2) >> sh;
        return WIDTH'(t | r);
    endfunction

    assign first_pat     = first_pattern(zero_cnt);
    assign final_pat_new = final_pattern(zero_cnt);
    assign final_pat_cur = final_pattern(k_q);
    assign next_pat      = next_pattern(data_q);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        k_d     = k_q;
        last_d  = last_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (zero_cnt > KW'(WIDTH)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        k_d     = zero_cnt;
                        data_d  = first_pat;
                        idx_d   = '0;
                        last_d  = (first_pat == final_pat_new);
                    end
                end
            end
            RUN: begin
                if (ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        data_d = next_pat;
                        idx_d  = idx_q + 1'b1;
                        last_d = (next_pat == final_pat_cur);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            k_q     <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data  = data_q;
    assign valid = (state_q == RUN);
    assign busy  = (state_q == RUN);
    assign last  = last_q;
    assign idx   = idx_q;
    assign done  = done_q;
    assign err   = err_q;

`ifdef ZERO_CHECK_EN
    logic chk_err_q, chk_err_d;
    logic [KW-1:0] data_zeros;

    function automatic logic [KW-1:0] count_zeros(input logic [WIDTH-1:0] d);
        logic [KW-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) if (!d[i]) n = n + 1'b1;
        return n;
    endfunction

    assign data_zeros = count_zeros(data_q);

    always_comb begin
        chk_err_d = chk_err_q;
        if (valid && (data_zeros != k_q)) chk_err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) chk_err_q <= 1'b0;
        else     chk_err_q <= chk_err_d;
    end

    assign chk_err = chk_err_q;
`endif

endmodule

// File: tb/tb_zero_count_pattern_gen.sv
// Randomized self-checking bench for zero_count_pattern_gen against an enumerated reference list.
module tb_zero_count_pattern_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] zero_cnt;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic [6:0] idx;
    logic       busy;
    logic       done;
    logic       err;
`ifdef ZERO_CHECK_EN
    logic       chk_err;
`endif

    int n_cmp;
    int n_bad;

    zero_count_pattern_gen #(.WIDTH(8), .KW(4), .IDX_W(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .zero_cnt (zero_cnt),
        .ready    (ready),
        .data     (data),
        .valid    (valid),
        .last     (last),
        .idx      (idx),
        .busy     (busy),
        .done     (done),
        .err      (err)
`ifdef ZERO_CHECK_EN
        ,
        .chk_err  (chk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: all bytes with exactly k zero bits, ascending.
    logic [7:0] exp_q[$];

    task automatic build_model(input int k);
        logic [7:0] b;
        exp_q.delete();
        for (int v = 0; v < 256; v++) begin
            b = v[7:0];
            if ((8 - $countones(b)) == k) exp_q.push_back(b);
        end
    endtask

    // mode: 0 ready always high, 1 random ready, 2 three stalls then random.
    // inj: cycle index at which a stray start (K=2) is pulsed, -1 for none.
    // abort_at: transfer count at which rst is asserted mid-cycle, -1 for none.
    task automatic run_seq(input int k, input int mode, input int inj, input int abort_at);
        int n;
        int cyc;
        logic [7:0] lastdata;
        build_model(k);
        n = 0;
        cyc = 0;
        @(negedge clk);
        start = 1'b1;
        zero_cnt = 4'(k);
        ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        zero_cnt = 4'($urandom_range(0, 15));
        n_cmp++;
        if (valid !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL latency_k%0d: valid=%b busy=%b, required 1 1", k, valid, busy);
        end
        while (n < exp_q.size()) begin
            if (n == abort_at) begin
                #2 rst = 1'b1;
                #1;
                n_cmp++;
                if (data !== 8'h00 || valid !== 1'b0 || last !== 1'b0 || idx !== 7'd0 ||
                    busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL abort_outputs: data=%h valid=%b last=%b idx=%0d busy=%b done=%b err=%b, required all 0",
                             data, valid, last, idx, busy, done, err);
                end
                @(negedge clk);
                rst = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (done !== 1'b0 || valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL abort_no_done: done=%b valid=%b, required 0 0", done, valid);
                    end
                end
                return;
            end
            if (mode == 0) ready = 1'b1;
            else if (mode == 2 && cyc < 3) ready = 1'b0;
            else ready = ($urandom_range(0, 2) != 0);
            start = (cyc == inj);
            zero_cnt = (cyc == inj) ? 4'd2 : zero_cnt;
            n_cmp++;
            if (valid !== 1'b1 || busy !== 1'b1 || data !== exp_q[n] || idx !== 7'(n) ||
                last !== (n == exp_q.size() - 1)) begin
                n_bad++;
                $display("FAIL seq_k%0d_n%0d: valid=%b busy=%b data=%h idx=%0d last=%b, required 1 1 %h %0d %b",
                         k, n, valid, busy, data, idx, last, exp_q[n], n, (n == exp_q.size() - 1));
            end
            lastdata = data;
            if (ready) n++;
            cyc++;
            if (cyc > 2000) begin
                n_bad++;
                $display("FAIL timeout_k%0d: transfers=%0d, required %0d", k, n, exp_q.size());
                break;
            end
            @(negedge clk);
            start = 1'b0;
        end
        ready = $urandom_range(0, 1);
        n_cmp++;
        if (valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || last !== 1'b0) begin
            n_bad++;
            $display("FAIL done_k%0d: valid=%b done=%b busy=%b last=%b, required 0 1 0 0", k, valid, done, busy, last);
        end
        n_cmp++;
        if (data !== lastdata) begin
            n_bad++;
            $display("FAIL data_hold_k%0d: data=%h, required %h", k, data, lastdata);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL done_pulse_k%0d: done=%b valid=%b, required 0 0", k, done, valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        zero_cnt = 4'd0;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (data !== 8'h00 || valid !== 1'b0 || last !== 1'b0 || idx !== 7'd0 ||
            busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: data=%h valid=%b last=%b idx=%0d busy=%b done=%b err=%b, required all 0",
                     data, valid, last, idx, busy, done, err);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_seq(6, 0, -1, -1);
    endtask

    task automatic test_single();
        run_seq(8, 0, -1, -1);
        run_seq(0, 1, -1, -1);
    endtask

    task automatic test_stall();
        run_seq(7, 2, -1, -1);
    endtask

    task automatic test_err();
        @(negedge clk);
        start = 1'b1;
        zero_cnt = 4'd9;
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (err !== 1'b1 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pulse: err=%b valid=%b busy=%b done=%b, required 1 0 0 0", err, valid, busy, done);
        end
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b0 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear: err=%b valid=%b, required 0 0", err, valid);
        end
        run_seq(4, 0, -1, -1);
    endtask

    task automatic test_abort();
        run_seq(4, 1, -1, 10);
        run_seq(4, 0, -1, -1);
    endtask

    task automatic test_start_ignored();
        run_seq(5, 1, 4, -1);
        n_cmp++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_start: valid=%b busy=%b, required 0 0", valid, busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) run_seq($urandom_range(0, 8), 1, -1, -1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_single();
        test_stall();
        test_err();
        test_abort();
        test_start_ignored();
        test_random();
`ifdef ZERO_CHECK_EN
        n_cmp++;
        if (chk_err !== 1'b0) begin
            n_bad++;
            $display("FAIL chk_err: chk_err=%b, required 0", chk_err);
        end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
